// File: rtl/my_mux2.sv
// my_mux2: 4:1 selector with combinational and registered outputs.
// Define MY_MUX2_SEL_STATS_EN to add the saturating sel_changes counter.
module my_mux2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s0,
    input  logic             s1,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       sel_onehot,
    output logic [WIDTH-1:0] y_q,
`ifdef MY_MUX2_SEL_STATS_EN
    output logic             y_q_valid,
    output logic [15:0]      sel_changes
`else
    output logic             y_q_valid
`endif
);

    logic [1:0] sel;

    assign sel        = {s1, s0};
    assign sel_onehot = 4'b0001 << sel;

    // An unknown select decodes to no hot bit, so y falls to X.
    always_comb begin
        y = 'x;
        unique case (1'b1)
            sel_onehot[0]: y = a;
            sel_onehot[1]: y = b;
            sel_onehot[2]: y = c;
            sel_onehot[3]: y = d;
            default:       y = 'x;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q       <= '0;
            y_q_valid <= 1'b0;
        end else begin
            y_q_valid <= en;
            if (en) begin
                y_q <= y;
            end
        end
    end

`ifdef MY_MUX2_SEL_STATS_EN
    logic [1:0] prev_sel;
    logic       prev_ok;

    // First edge after reset only seeds prev_sel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_sel    <= 2'b00;
            prev_ok     <= 1'b0;
            sel_changes <= 16'h0000;
        end else begin
            prev_sel <= sel;
            prev_ok  <= 1'b1;
            if (prev_ok && (sel != prev_sel) &&
                (sel_changes != 16'hFFFF)) begin
                sel_changes <= sel_changes + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_my_mux2.sv
// tb_my_mux2: directed vectors for my_mux2 at WIDTH=1 and WIDTH=8.
// Covers mapping, registered path, async reset and optional stats.
module tb_my_mux2;

    logic       clk;
    logic       rst_n;
    logic       s0;
    logic       s1;
    logic       en;
    logic       a1, b1, c1, d1;
    logic       y1;
    logic [3:0] oh1;
    logic       yq1;
    logic       v1;
    logic [7:0] a8, b8, c8, d8;
    logic [7:0] y8;
    logic [3:0] oh8;
    logic [7:0] yq8;
    logic       v8;
`ifdef MY_MUX2_SEL_STATS_EN
    logic [15:0] cnt1;
    logic [15:0] cnt8;
`endif

    int n_vec;
    int n_err;

    my_mux2 #(.WIDTH(1)) u1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .s0         (s0),
        .s1         (s1),
        .a          (a1),
        .b          (b1),
        .c          (c1),
        .d          (d1),
        .en         (en),
        .y          (y1),
        .sel_onehot (oh1),
        .y_q        (yq1),
`ifdef MY_MUX2_SEL_STATS_EN
        .y_q_valid  (v1),
        .sel_changes(cnt1)
`else
        .y_q_valid  (v1)
`endif
    );

    my_mux2 #(.WIDTH(8)) u8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .s0         (s0),
        .s1         (s1),
        .a          (a8),
        .b          (b8),
        .c          (c8),
        .d          (d8),
        .en         (en),
        .y          (y8),
        .sel_onehot (oh8),
        .y_q        (yq8),
`ifdef MY_MUX2_SEL_STATS_EN
        .y_q_valid  (v8),
        .sel_changes(cnt8)
`else
        .y_q_valid  (v8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_sel(input int s);
        s1 = (s >> 1) & 1;
        s0 = s & 1;
    endtask

    // Advance one edge, then settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] v;
        logic [3:0] exp_oh [4];
        logic [7:0] exp_w  [4];
        int         seq    [6];

        exp_oh = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_w  = '{8'h5A, 8'hA5, 8'hFF, 8'h00};
        seq    = '{0, 0, 1, 3, 3, 2};
        n_vec  = 0;
        n_err  = 0;

        rst_n = 1'b0;
        en    = 1'b0;
        set_sel(0);
        {a1, b1, c1, d1} = 4'b0000;
        {a8, b8, c8, d8} = 32'h0;
        #2;
        chk("rst_yq",    32'(yq1), 32'h0);
        chk("rst_valid", 32'(v1),  32'h0);
        chk("rst_yq8",   32'(yq8), 32'h0);
`ifdef MY_MUX2_SEL_STATS_EN
        chk("rst_cnt",   32'(cnt1), 32'h0);
`endif

        // Mapping from the plan: c=1 only.
        {a1, b1, c1, d1} = 4'b0010;
        set_sel(0);
        #1;
        chk("map00_y",  32'(y1),  32'h0);
        chk("map00_oh", 32'(oh1), 32'h1);
        set_sel(2);
        #1;
        chk("map10_y",  32'(y1),  32'h1);
        chk("map10_oh", 32'(oh1), 32'h4);

        // Exhaustive, no clock edges required; a is v[3], d is v[0].
        for (int si = 0; si < 4; si++) begin
            for (int vi = 0; vi < 16; vi++) begin
                v = 4'(vi);
                {a1, b1, c1, d1} = v;
                set_sel(si);
                #1;
                chk("exh_y", 32'(y1), 32'(v[3-si]));
            end
            chk("exh_oh", 32'(oh1), 32'(exp_oh[si]));
        end

        // Registered path.
        #2;
        rst_n = 1'b1;
        {a1, b1, c1, d1} = 4'b0001;
        set_sel(3);
        en = 1'b1;
        tick();
        chk("cap_yq",    32'(yq1), 32'h1);
        chk("cap_valid", 32'(v1),  32'h1);
        en = 1'b0;
        d1 = 1'b0;
        tick();
        chk("hold_yq",    32'(yq1), 32'h1);
        chk("hold_valid", 32'(v1),  32'h0);

        // Back-to-back captures on the wide instance.
        a8 = 8'h5A; b8 = 8'hA5; c8 = 8'hFF; d8 = 8'h00;
        en = 1'b1;
        set_sel(0);
        tick();
        chk("b2b0_yq8", 32'(yq8), 32'h5A);
        chk("b2b0_v8",  32'(v8),  32'h1);
        set_sel(1);
        tick();
        chk("b2b1_yq8", 32'(yq8), 32'hA5);
        chk("b2b1_v8",  32'(v8),  32'h1);
        en = 1'b0;

        // Wide combinational stepping.
        for (int si = 0; si < 4; si++) begin
            set_sel(si);
            #1;
            chk("wide_y8", 32'(y8), 32'(exp_w[si]));
            chk("wide_oh", 32'(oh8), 32'(exp_oh[si]));
        end

        // Async reset between edges while y keeps tracking.
        {a1, b1, c1, d1} = 4'b1111;
        set_sel(0);
        en = 1'b1;
        tick();
        chk("pre_rst_yq", 32'(yq1), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_yq",    32'(yq1), 32'h0);
        chk("arst_valid", 32'(v1),  32'h0);
        chk("arst_yq8",   32'(yq8), 32'h0);
        c1 = 1'b0;
        set_sel(2);
        #1;
        chk("arst_y_tracks", 32'(y1), 32'h0);
        tick();
        chk("arst_hold_yq", 32'(yq1), 32'h0);
        chk("arst_hold_v",  32'(v1),  32'h0);

        // First capture after release.
        en = 1'b0;
        rst_n = 1'b1;
        set_sel(1);
        tick();
        chk("post_noen_yq", 32'(yq1), 32'h0);
        en = 1'b1;
        tick();
        chk("post_cap_yq", 32'(yq1), 32'h1);
        en = 1'b0;

`ifdef MY_MUX2_SEL_STATS_EN
        rst_n = 1'b0;
        #1;
        chk("cnt_rst", 32'(cnt1), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_sel(seq[i]);
            tick();
        end
        chk("cnt_seq",  32'(cnt1), 32'h3);
        chk("cnt_seq8", 32'(cnt8), 32'h3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
